// File: rtl/spi_accel_target.sv
// rtl/spi_accel_target.sv - SPI mode-0 accelerometer register target, sampled in the clk domain
module spi_accel_target #(
    parameter int         NUM_REGS = 64,
    parameter logic [7:0] DEVID    = 8'hAD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] sample_x,
    input  logic [7:0] sample_y,
    input  logic [7:0] sample_z,
    input  logic       sample_valid,
    output logic       measure
);
    localparam int         AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0] NREGS = 9'(NUM_REGS);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_WDATA  = 3'd3;
    localparam logic [2:0] ST_RDATA  = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

    localparam logic [AW-1:0] IDX_X    = AW'(8'h08);
    localparam logic [AW-1:0] IDX_Y    = AW'(8'h09);
    localparam logic [AW-1:0] IDX_Z    = AW'(8'h0A);
    localparam logic [AW-1:0] IDX_MEAS = AW'(8'h2D);

    logic [2:0] sclk_q, cs_q;
    logic [1:0] mosi_q;
    logic [7:0] regs_q [NUM_REGS];
    logic [2:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, addr_q, addr_d, tx_q, tx_d;
    logic       is_read_q, is_read_d, miso_q, miso_d, oe_q, oe_d, arm_q, arm_d;
    logic       pend_q;
    logic [7:0] pend_x_q, pend_y_q, pend_z_q;

    logic       sclk_rise, sclk_fall, cs_rise, cs_fall, cs_stable_hi;
    logic       byte_done, wr_en, srst, sample_ok;
    logic [7:0] rx_byte, rd_addr, rd_data;

    // Stage 2 ([1]) is the synchronized level; stage 3 ([2]) is its one-cycle history.
    assign sclk_rise    = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall    = ~sclk_q[1] & sclk_q[2];
    assign cs_rise      = cs_q[1] & ~cs_q[2];
    assign cs_fall      = ~cs_q[1] & cs_q[2];
    assign cs_stable_hi = cs_q[1] & cs_q[2];

    assign rx_byte   = {shift_q[6:0], mosi_q[1]};
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7) && (state_q != ST_IDLE);
    assign srst      = cs_rise && arm_q;
    assign sample_ok = sample_valid && measure;

    assign measure = (regs_q[IDX_MEAS][1:0] == 2'b10);
    assign miso    = miso_q;
    assign miso_oe = oe_q;

    function automatic logic in_range(input logic [7:0] a);
        return {1'b0, a} < NREGS;
    endfunction

    function automatic logic writable(input logic [7:0] a);
        return in_range(a) && !(a inside {8'h00, 8'h01, 8'h08, 8'h09, 8'h0A, 8'h1F});
    endfunction

    // One read port serves both the first fetch (address byte) and burst reloads.
    assign rd_addr = (state_q == ST_ADDR) ? rx_byte : addr_q + 8'd1;
    assign rd_data = (in_range(rd_addr) && rd_addr != 8'h1F) ? regs_q[rd_addr[AW-1:0]] : 8'h00;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        is_read_d = is_read_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        arm_d     = arm_q;
        wr_en     = 1'b0;
        if (cs_rise) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
            oe_d    = 1'b0;
            arm_d   = 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (cs_fall) begin
                state_d   = ST_CMD;
                bit_cnt_d = 3'd0;
            end
        end else begin
            if (sclk_rise) begin
                shift_d   = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            if (state_q == ST_RDATA && sclk_fall) begin
                miso_d = tx_q[7];
                tx_d   = {tx_q[6:0], 1'b0};
                oe_d   = 1'b1;
            end
            if (byte_done) begin
                case (state_q)
                    ST_CMD: begin
                        if (rx_byte == 8'h0A) begin
                            state_d   = ST_ADDR;
                            is_read_d = 1'b0;
                        end else if (rx_byte == 8'h0B) begin
                            state_d   = ST_ADDR;
                            is_read_d = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                    ST_ADDR: begin
                        addr_d = rx_byte;
                        if (is_read_q) begin
                            tx_d    = rd_data;
                            state_d = ST_RDATA;
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end
                    ST_WDATA: begin
                        wr_en  = writable(addr_q);
                        arm_d  = arm_q | (addr_q == 8'h1F && rx_byte == 8'h52);
                        addr_d = addr_q + 8'd1;
                    end
                    ST_RDATA: begin
                        addr_d = addr_q + 8'd1;
                        tx_d   = rd_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q    <= 3'b000;
            cs_q      <= 3'b111;
            mosi_q    <= 2'b00;
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            addr_q    <= 8'h00;
            is_read_q <= 1'b0;
            tx_q      <= 8'h00;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            arm_q     <= 1'b0;
        end else begin
            sclk_q    <= {sclk_q[1:0], sclk};
            cs_q      <= {cs_q[1:0], cs};
            mosi_q    <= {mosi_q[0], mosi};
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            is_read_q <= is_read_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            arm_q     <= arm_d;
        end
    end

    // Samples landing while cs is low (or on its rising edge) wait in the pending buffer.
    always_ff @(posedge clk) begin
        if (rst || srst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == 0) ? DEVID : (i == 1) ? 8'h1D : 8'h00;
            end
            pend_q   <= 1'b0;
            pend_x_q <= 8'h00;
            pend_y_q <= 8'h00;
            pend_z_q <= 8'h00;
        end else begin
            if (wr_en) begin
                regs_q[addr_q[AW-1:0]] <= rx_byte;
            end
            if (sample_ok && cs_stable_hi) begin
                regs_q[IDX_X] <= sample_x;
                regs_q[IDX_Y] <= sample_y;
                regs_q[IDX_Z] <= sample_z;
                pend_q        <= 1'b0;
            end else if (sample_ok) begin
                pend_q   <= 1'b1;
                pend_x_q <= sample_x;
                pend_y_q <= sample_y;
                pend_z_q <= sample_z;
            end else if (pend_q && cs_stable_hi) begin
                regs_q[IDX_X] <= pend_x_q;
                regs_q[IDX_Y] <= pend_y_q;
                regs_q[IDX_Z] <= pend_z_q;
                pend_q        <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_accel_target.sv
// tb/tb_spi_accel_target.sv - directed bench for spi_accel_target
module tb_spi_accel_target;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe, measure;
    logic [7:0] sample_x = 8'h00, sample_y = 8'h00, sample_z = 8'h00;
    logic       sample_valid = 1'b0;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic       byte_oe;
    logic [7:0] rx0, rx1, rx2, rx3;

    spi_accel_target #(.NUM_REGS(64), .DEVID(8'hAD)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
        .sample_valid(sample_valid), .measure(measure)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        wait_clks(6);
    endtask

    task automatic cs_high();
        wait_clks(6);
        cs = 1'b1;
        wait_clks(8);
    endtask

    // Mode 0: drive mosi while sclk low, sample miso just before the rising edge.
    task automatic xbits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            wait_clks(6);
            if (i == 7) byte_oe = miso_oe;
            rx[i] = miso;
            sclk = 1'b1;
            wait_clks(6);
            sclk = 1'b0;
        end
    endtask

    task automatic xbyte(input logic [7:0] tx, output logic [7:0] rx);
        xbits(tx, 8, rx);
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] r;
        cs_low();
        xbyte(8'h0A, r);
        xbyte(a, r);
        xbyte(d, r);
        cs_high();
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [7:0] d);
        logic [7:0] r;
        cs_low();
        xbyte(8'h0B, r);
        xbyte(a, r);
        xbyte(8'h00, d);
        cs_high();
    endtask

    initial begin
        logic [7:0] r;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(2);
        check("reset_miso", miso, 1'b0);
        check("reset_oe", miso_oe, 1'b0);
        check("reset_measure", measure, 1'b0);

        cs_low();
        xbyte(8'h0B, r);
        check("devid_oe_b1", byte_oe, 1'b0);
        xbyte(8'h00, r);
        check("devid_oe_b2", byte_oe, 1'b0);
        xbyte(8'h00, rx0);
        check("devid_oe_b3", byte_oe, 1'b1);
        check("devid_data", rx0, 8'hAD);
        cs_high();
        check("devid_oe_after", miso_oe, 1'b0);

        cs_low();
        xbyte(8'h0B, r);
        xbyte(8'h00, r);
        xbyte(8'h00, rx0);
        xbyte(8'h00, rx1);
        cs_high();
        check("burst_r00", rx0, 8'hAD);
        check("burst_r01", rx1, 8'h1D);

        wr_reg(8'h2D, 8'h02);
        check("measure_on", measure, 1'b1);

        cs_low();
        xbyte(8'h0B, r);
        xbyte(8'h08, r);
        sample_x = 8'h12; sample_y = 8'h34; sample_z = 8'h56;
        sample_valid = 1'b1;
        wait_clks(1);
        sample_valid = 1'b0;
        xbyte(8'h00, rx0);
        xbyte(8'h00, rx1);
        cs_high();
        check("sample_old_x", rx0, 8'h00);
        check("sample_old_y", rx1, 8'h00);
        cs_low();
        xbyte(8'h0B, r);
        xbyte(8'h08, r);
        xbyte(8'h00, rx0);
        xbyte(8'h00, rx1);
        xbyte(8'h00, rx2);
        cs_high();
        check("sample_x", rx0, 8'h12);
        check("sample_y", rx1, 8'h34);
        check("sample_z", rx2, 8'h56);

        cs_low();
        xbyte(8'h0A, r);
        xbyte(8'h20, r);
        xbyte(8'hA5, r);
        xbyte(8'h5A, r);
        cs_high();
        rd_reg(8'h20, rx0);
        rd_reg(8'h21, rx1);
        check("wr_r20", rx0, 8'hA5);
        check("wr_r21", rx1, 8'h5A);
        wr_reg(8'h00, 8'hFF);
        rd_reg(8'h00, rx0);
        check("devid_ro", rx0, 8'hAD);

        wr_reg(8'h3F, 8'hC3);
        wr_reg(8'h50, 8'h77);
        cs_low();
        xbyte(8'h0B, r);
        xbyte(8'h3F, r);
        xbyte(8'h00, rx0);
        xbyte(8'h00, rx1);
        cs_high();
        check("edge_r3f", rx0, 8'hC3);
        check("oor_r40", rx1, 8'h00);
        rd_reg(8'h50, rx0);
        check("oor_r50", rx0, 8'h00);

        wr_reg(8'h1F, 8'h51);
        check("srst51_measure", measure, 1'b1);
        rd_reg(8'h20, rx0);
        check("srst51_r20", rx0, 8'hA5);
        wr_reg(8'h1F, 8'h52);
        check("srst_measure", measure, 1'b0);
        rd_reg(8'h20, rx0);
        check("srst_r20", rx0, 8'h00);
        rd_reg(8'h08, rx0);
        check("srst_r08", rx0, 8'h00);
        rd_reg(8'h3F, rx0);
        check("srst_r3f", rx0, 8'h00);

        wr_reg(8'h22, 8'h33);
        cs_low();
        xbyte(8'h0A, r);
        xbyte(8'h22, r);
        xbits(8'hF0, 4, r);
        cs_high();
        rd_reg(8'h22, rx0);
        check("abort_r22", rx0, 8'h33);

        cs_low();
        xbyte(8'h0C, r);
        xbyte(8'h00, r);
        check("unk_oe_b2", byte_oe, 1'b0);
        xbyte(8'h00, rx0);
        check("unk_oe_b3", byte_oe, 1'b0);
        check("unk_miso", rx0, 8'h00);
        check("unk_oe_end", miso_oe, 1'b0);
        cs_high();
        rd_reg(8'h01, rx3);
        check("post_unk_r01", rx3, 8'h1D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got running expected done");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/spi_accel_target.md
# spi_accel_target

Register-level SPI target (responder) that models the accelerometer side of the sensor link: it decodes the 3-byte write and 2+N-byte read transactions issued by the SPI master controller (write 0x0A, read 0x0B, measurement enable via 0x2D, soft reset via 0x1F/0x52) and returns register and sample data on MISO. It is used as the on-chip sensor model in system simulation and on FPGA loopback builds, and is sampled entirely in the `clk` domain.

## Interface
- NUM_REGS, 64: register-file depth; address bits above log2(NUM_REGS) are decoded as out-of-range.
- DEVID, 8'hAD: reset/read-only value of register 0x00.
- clk  in  1  system clock; the block uses one clock.
- rst  in  1  reset; synchronous and active-high.
- sclk  in  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
- cs  in  1  chip select, active low, asynchronous.
- mosi  in  1  master-out data, MSB first.
- miso  out  1  target-out data, MSB first; 0 when not driving.
- miso_oe  out  1  high while a read data phase is in progress.
- sample_x, sample_y, sample_z  in  8 each  new sample values.
- sample_valid  in  1  one-cycle strobe qualifying sample_*.
- measure  out  1  high when reg 0x2D[1:0] == 2'b10.

## Operation
- Input conditioning: sclk, cs, mosi each pass through a 2-flop synchronizer; rise/fall of sclk and cs detected from synchronized stage 2 vs. a third flop.
- Transaction FSM: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
  - IDLE -> CMD on cs falling edge; bit counter cleared.
  - Bits shift in on sclk rise; byte complete after 8th rise.
  - CMD: 0x0A -> ADDR (write), 0x0B -> ADDR (read), other -> IGNORE.
  - ADDR: latch address; write -> WDATA; read -> fetch reg[addr] into TX shift register -> RDATA.
  - WDATA: each complete byte written to reg[addr]; addr increments.
  - RDATA: each complete byte (MOSI content ignored) increments addr and reloads TX shift register with reg[addr+1].
  - Any state -> IDLE on cs rising edge, regardless of bit count; partial bytes discarded, no write occurs.
- Address increment wraps modulo 256; addresses >= NUM_REGS read 0x00, writes dropped.
- Register map: 0x00 DEVID (RO), 0x01 0x1D (RO), 0x08/0x09/0x0A XDATA/YDATA/ZDATA (RO), 0x1F SOFT_RESET (WO, reads 0x00), all others RW, reset 0x00. Writes to RO registers are dropped.
- MISO: in RDATA, TX bit 7 driven on the first sclk fall after the address byte completes; subsequent bits shift on each sclk fall. miso_oe high from that fall until cs rises.
- Samples: on sample_valid with measure=1 and cs synchronized high, XDATA/YDATA/ZDATA load together. If cs is low, the sample is held in a pending buffer (latest wins) and committed in the cycle after cs rises. Samples are ignored when measure=0.
- Soft reset: a completed write of 0x52 to 0x1F arms a flag; on the cs rising edge ending that transaction, all registers, the pending buffer and measure return to reset values. Any other value written to 0x1F has no effect.

## Timing
- Reset (rst high at clk rise): miso=0, miso_oe=0, measure=0, FSM IDLE, registers at reset values, pending buffer empty, synchronizer flops 0 for sclk/mosi and 1 for cs.
- Requirements: sclk high and low times >= 4 clk periods; cs setup to first sclk rise and hold after last sclk fall >= 4 clk periods.
- Edge latency: internal action occurs 3 clk cycles after the external edge. miso updates at most 4 clk cycles after sclk fall.
- measure updates in the cycle after the 0x2D data byte completes.
- Simultaneous sample_valid and cs rise: the sample goes to the pending buffer and commits one cycle later.
- rst mid-transaction returns to IDLE; the transaction resumes only after a new cs falling edge.

## Test plan
- Read DEVID: cs low, 0x0B 0x00 0x00 -> third byte on MISO 0xAD; miso_oe high only during the third byte.
- Burst read: 0x0B 0x00 plus 2 dummy bytes -> 0xAD, 0x1D; then write 0x0A 0x2D 0x02 -> measure=1.
- Samples: measure=1, sample_valid with x=0x12, y=0x34, z=0x56 while cs low -> read of 0x08 in that transaction returns old data; the next burst read of 0x08 returns 0x12 0x34 0x56.
- Write/readback: 0x0A 0x20 0xA5 0x5A -> reads return 0x20=0xA5, 0x21=0x5A. Write 0xFF to 0x00 -> 0x00 still reads 0xAD.
- Soft reset: 0x0A 0x1F 0x52 -> measure=0 after cs rises and 0x20 reads 0x00. Writing 0x51 to 0x1F -> no change.
- Abort: cs rises after 4 bits of a write data byte -> target register unchanged, FSM IDLE; unknown command 0x0C -> miso_oe stays 0.
